im_boot_loader: RTL and testbench

//  Boot-time loader upstream of the pipeline core. Accepts a framed program stream (length, words, checksum)
//  on a valid/ready port and writes each word into instruction memory via that SRAM's write port.

---
 rtl/im_boot_loader.sv | 136 +++++++++++++
 tb/tb_im_boot_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_boot_loader.sv
// Boot-time program loader. It takes a framed image from a valid/ready stream:
// a length word, then that many program words, then a 32-bit additive checksum.
// Each program word is written into instruction memory one cycle after it is
// accepted. The core is held in reset until the whole image has been written
// and its checksum matches.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start
// LEN   | waiting for the length word
// LOAD  | accepting program words and writing them to IM
// CSUM  | waiting for the checksum word
// DONE  | image verified, core released; only rst leaves this state
// ERR   | bad length or checksum mismatch; start begins a retry
module im_boot_loader #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic [3:0]        im_w_en,
    output logic [ADDR_W-1:0] im_address,
    output logic [31:0]       im_write_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LOAD,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

    state_t      state;
    logic [15:0] len;
    logic [31:0] sum;
    logic        accept;

    // in_ready is itself a register, so the handshake needs no extra state.
    assign accept = in_valid & in_ready;

    // Loader FSM; every output is set on the transition into the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            len           <= '0;
            sum           <= '0;
            in_ready      <= 1'b0;
            im_w_en       <= 4'h0;
            im_address    <= '0;
            im_write_data <= '0;
            cpu_rst       <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            word_cnt      <= '0;
        end else begin
            // A write strobe lasts exactly one cycle unless LOAD re-arms it.
            im_w_en <= 4'h0;
            unique case (state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        state    <= S_LEN;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        error    <= 1'b0;
                        word_cnt <= '0;
                        sum      <= '0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        // Full 32-bit compare so large lengths cannot alias into range.
                        if (in_data == 32'd0 || in_data > MAX_LEN) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            len   <= in_data[15:0];
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        im_w_en       <= 4'hF;
                        im_address    <= ADDR_W'(32'(BASE_ADDR) + {14'd0, word_cnt, 2'b00});
                        im_write_data <= in_data;
                        sum           <= sum + in_data;
                        word_cnt      <= word_cnt + 16'd1;
                        if (word_cnt == len - 16'd1) begin
                            state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        // The last IM write is already on the bus this cycle, so
                        // releasing the core on the next edge keeps it ahead.
                        if (in_data == sum) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_boot_loader.sv
// Testbench for im_boot_loader: directed scenarios plus randomized images,
// checked against expectations computed from the frame contents.
module tb_im_boot_loader;

    localparam int MAXW = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  im_w_en;
    logic [15:0] im_address;
    logic [31:0] im_write_data;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] word_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_writes = 0;
    int last_wr_cyc = -1;
    logic prev_cpu_rst = 1'b1;

    logic [31:0] frame[$];

    im_boot_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .im_w_en      (im_w_en),
        .im_address   (im_address),
        .im_write_data(im_write_data),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .word_cnt     (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts IM writes and checks the core is released strictly after the last write.
    always @(negedge clk) begin
        cyc++;
        if (im_w_en !== 4'h0) begin
            n_writes++;
            last_wr_cyc = cyc;
            chk("w_en_value", 32'(im_w_en), 32'hF);
        end
        if (prev_cpu_rst === 1'b1 && cpu_rst === 1'b0)
            chk("release_after_last_write", 32'(last_wr_cyc < cyc), 32'd1);
        prev_cpu_rst = cpu_rst;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_w_en"}, 32'(im_w_en), 0);
        chk({tag, "_addr"}, 32'(im_address), 0);
        chk({tag, "_wdata"}, im_write_data, 0);
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_word_cnt"}, 32'(word_cnt), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_ready", 32'(in_ready), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_error_clr", 32'(error), 0);
        chk("start_word_cnt_clr", 32'(word_cnt), 0);
    endtask

    task automatic make_frame(input int n, input bit good);
        logic [31:0] s;
        s = 0;
        frame.delete();
        frame.push_back(32'(n));
        for (int i = 0; i < n; i++) begin
            frame.push_back($urandom);
            s = s + frame[i + 1];
        end
        frame.push_back(good ? s : s ^ (32'd1 << $urandom_range(0, 31)));
    endtask

    task automatic check_write(input bit exp_wr, input int idx);
        if (exp_wr) begin
            chk("w_en", 32'(im_w_en), 32'hF);
            chk("addr", 32'(im_address), 32'((4 * idx) % 65536));
            chk("wdata", im_write_data, frame[idx + 1]);
            chk("word_cnt_step", 32'(word_cnt), 32'(idx + 1));
        end else begin
            chk("no_write", 32'(im_w_en), 0);
        end
    endtask

    // mode 0: back-to-back valid; 1: random valid and random start pulses;
    // 2: valid pattern 1-0-0-1 around each accept.
    task automatic stream(input int mode, input int n_send, input bit rst_last);
        bit          prev_acc;
        int          prev_idx;
        int          gap_left;
        logic [31:0] len;
        prev_acc = 0; prev_idx = 0; gap_left = 0;
        len = frame[0];
        for (int j = 0; j < n_send; j++) begin
            bit acc;
            int budget;
            acc = 0; budget = 0;
            while (!acc) begin
                @(negedge clk);
                check_write(prev_acc, prev_idx);
                chk("busy_in_frame", 32'(busy), 1);
                chk("cpu_rst_in_frame", 32'(cpu_rst), 1);
                prev_acc = 0;
                case (mode)
                    0: in_valid = 1'b1;
                    1: in_valid = ($urandom_range(0, 2) != 0);
                    default: begin
                        in_valid = (gap_left == 0);
                        if (gap_left > 0) gap_left--;
                    end
                endcase
                start = (mode == 1) ? ($urandom_range(0, 4) == 0) : 1'b0;
                in_data = frame[j];
                if (in_valid && in_ready) begin
                    acc = 1;
                end else begin
                    budget++;
                    if (budget > 100) begin
                        chk("accept_timeout", 32'(acc), 1);
                        in_valid = 1'b0; start = 1'b0;
                        return;
                    end
                end
            end
            gap_left = 2;
            prev_idx = j - 1;
            prev_acc = (j >= 1) && (32'(j) <= len);
            if (rst_last && j == n_send - 1) begin
                rst = 1'b1;
                prev_acc = 0;
            end
        end
        @(negedge clk);
        check_write(prev_acc, prev_idx);
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input int w0);
        logic [31:0] len;
        logic [31:0] s;
        bit          bad;
        bit          ok;
        len = frame[0];
        bad = (len == 0) || (len > MAXW);
        s = 0;
        if (!bad) for (int i = 1; i <= int'(len); i++) s = s + frame[i];
        ok = !bad && (frame[len + 1] == s);
        chk({tag, "_done"}, 32'(done), 32'(ok));
        chk({tag, "_error"}, 32'(error), 32'(!ok));
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!ok));
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_word_cnt"}, 32'(word_cnt), bad ? 0 : len);
        chk({tag, "_writes"}, 32'(n_writes - w0), bad ? 0 : len);
    endtask

    task automatic run_frame(input string tag, input int mode);
        int w0;
        logic [31:0] len;
        len = frame[0];
        w0 = n_writes;
        pulse_start();
        if (len == 0 || len > MAXW) stream(mode, 1, 0);
        else stream(mode, int'(len) + 2, 0);
        check_result(tag, w0);
    endtask

    // Holds in_valid (and optionally start) with the loader not ready; nothing may change.
    task automatic idle_poke(input string tag, input bit with_start);
        int          w0;
        logic        d0, e0, c0;
        logic [15:0] wc0;
        w0 = n_writes; d0 = done; e0 = error; c0 = cpu_rst; wc0 = word_cnt;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = $urandom;
            start    = with_start && (k == 1);
        end
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_no_writes"}, 32'(n_writes - w0), 0);
        chk({tag, "_done_hold"}, 32'(done), 32'(d0));
        chk({tag, "_error_hold"}, 32'(error), 32'(e0));
        chk({tag, "_cpu_rst_hold"}, 32'(cpu_rst), 32'(c0));
        chk({tag, "_word_cnt_hold"}, 32'(word_cnt), 32'(wc0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;

        // IDLE ignores stream traffic.
        idle_poke("idle", 0);

        // Reference image, back-to-back.
        frame = '{32'd3, 32'h00000013, 32'h00100093, 32'h00208113, 32'h003081B9};
        run_frame("t1", 0);
        chk("t1_final_addr", 32'(im_address), 32'h8);

        // start and traffic in DONE are ignored.
        idle_poke("done_start", 1);

        // Bad checksum, then retry from ERR with the good image.
        do_reset();
        frame = '{32'd3, 32'h00000013, 32'h00100093, 32'h00208113, 32'h003081B8};
        run_frame("t2_bad", 0);
        idle_poke("err_traffic", 0);
        frame = '{32'd3, 32'h00000013, 32'h00100093, 32'h00208113, 32'h003081B9};
        run_frame("t2_retry", 0);

        // Illegal lengths.
        do_reset();
        frame = '{32'd0};
        run_frame("t3_zero", 0);
        frame = '{32'(MAXW + 1)};
        run_frame("t3_max_plus1", 0);
        frame = '{32'h0001_0002};
        run_frame("t3_wide", 0);

        // Gapped valid.
        do_reset();
        frame = '{32'd3, 32'h00000013, 32'h00100093, 32'h00208113, 32'h003081B9};
        run_frame("t4", 2);

        // Reset while the second program word is being accepted.
        do_reset();
        make_frame(3, 1);
        pulse_start();
        stream(0, 3, 1);
        check_reset_vals("t5_mid_rst");
        rst = 1'b0;
        run_frame("t5_reload", 0);

        // Randomized images with random valid and stray start pulses.
        for (int it = 0; it < 10; it++) begin
            do_reset();
            make_frame($urandom_range(1, 24), $urandom_range(0, 3) != 0);
            run_frame("rand", 1);
        end

        // Largest legal image: last write lands at byte address 0xFFFC.
        do_reset();
        make_frame(MAXW, 1);
        run_frame("max_words", 0);
        chk("max_final_addr", 32'(im_address), 32'hFFFC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
